// File: rtl/lcd_frame_receiver.sv
// Receive end of the LCD panel video interface (HD, VD, DEN, R, G, B).
// Samples the stream on pixel-clock enables, rebuilds pixel coordinates and
// the RGB stream, checks line length and lines per frame, and reports a
// per-frame status. Optional feature: define LCD_RX_CHECKSUM_EN to enable
// the 24-bit per-frame pixel checksum on frame_sum (tied to 0 otherwise).
module lcd_frame_receiver #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned CNT_W    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_ce,
  input  logic             hd,
  input  logic             vd,
  input  logic             den,
  input  logic [7:0]       r,
  input  logic [7:0]       g,
  input  logic [7:0]       b,
  output logic             pix_valid,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic [23:0]      pix_rgb,
  output logic             frame_done,
  output logic             frame_ok,
  output logic             err_h,
  output logic             err_v,
  output logic [15:0]      frame_cnt,
  output logic [23:0]      frame_sum
);

  localparam logic [CNT_W-1:0] HLen   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VLen   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  typedef enum logic [0:0] {StSyncWait, StActive} state_e;

  state_e           state_q, state_d;
  logic             vd_q, vd_d;
  logic             den_q, den_d;
  logic             hd_q, hd_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             h_err_q, h_err_d;
  logic             pix_valid_q, pix_valid_d;
  logic [CNT_W-1:0] pix_x_q, pix_x_d;
  logic [CNT_W-1:0] pix_y_q, pix_y_d;
  logic [23:0]      pix_rgb_q, pix_rgb_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_ok_q, frame_ok_d;
  logic             err_h_q, err_h_d;
  logic             err_v_q, err_v_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic vd_fall;
  logic den_fall;
  logic y_short;

  // HD is kept registered for later use; it does not influence counting.
  logic unused_hd;
  assign unused_hd = hd_q;

  // Edges are taken against the previous accepted sample, not the previous clock.
  assign vd_fall  = vd_q & ~vd;
  assign den_fall = den_q & ~den;

  // Next-state for the FSM, line/frame counters and registered outputs.
  always_comb begin
    state_d      = state_q;
    vd_d         = vd_q;
    den_d        = den_q;
    hd_d         = hd_q;
    x_d          = x_q;
    y_d          = y_q;
    h_err_d      = h_err_q;
    pix_valid_d  = 1'b0;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_rgb_d    = pix_rgb_q;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    err_h_d      = err_h_q;
    err_v_d      = err_v_q;
    frame_cnt_d  = frame_cnt_q;
    y_short      = 1'b0;

    if (pix_ce) begin
      vd_d  = vd;
      den_d = den;
      hd_d  = hd;
      unique case (state_q)
        StSyncWait: begin
          if (vd_fall) begin
            state_d = StActive;
            x_d     = '0;
            y_d     = '0;
            h_err_d = 1'b0;
          end
        end
        StActive: begin
          // Line end is applied before frame end so a line closing in the
          // VD-fall sample still counts toward the old frame.
          if (den_fall) begin
            if (x_d != HLen) h_err_d = 1'b1;
            x_d = '0;
            if (y_d != CntMax) y_d = y_d + 1'b1;
          end
          if (vd_fall) begin
            y_short      = (y_d != VLen);
            frame_done_d = 1'b1;
            err_h_d      = h_err_d;
            err_v_d      = y_short;
            frame_ok_d   = ~(h_err_d | y_short);
            frame_cnt_d  = frame_cnt_q + 16'd1;
            x_d          = '0;
            y_d          = '0;
            h_err_d      = 1'b0;
          end
          // A pixel in the VD-fall sample belongs to the new frame.
          if (den) begin
            pix_valid_d = 1'b1;
            pix_x_d     = x_d;
            pix_y_d     = y_d;
            pix_rgb_d   = {r, g, b};
            if (x_d == CntMax) h_err_d = 1'b1;
            else               x_d     = x_d + 1'b1;
          end
        end
        default: state_d = StSyncWait;
      endcase
    end
  end

  // State and output registers; next-state logic already gates on pix_ce.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StSyncWait;
      vd_q         <= 1'b0;
      den_q        <= 1'b0;
      hd_q         <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      h_err_q      <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_rgb_q    <= '0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      err_h_q      <= 1'b0;
      err_v_q      <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      vd_q         <= vd_d;
      den_q        <= den_d;
      hd_q         <= hd_d;
      x_q          <= x_d;
      y_q          <= y_d;
      h_err_q      <= h_err_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_rgb_q    <= pix_rgb_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      err_h_q      <= err_h_d;
      err_v_q      <= err_v_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_rgb    = pix_rgb_q;
  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign err_h      = err_h_q;
  assign err_v      = err_v_q;
  assign frame_cnt  = frame_cnt_q;

`ifdef LCD_RX_CHECKSUM_EN
  logic [23:0] acc_q, acc_d;
  logic [23:0] sum_q, sum_d;

  // Checksum: the accumulator is snapshotted at frame end, then restarts with
  // any new-frame pixel carried in the same sample.
  always_comb begin
    acc_d = acc_q;
    sum_d = sum_q;
    if (pix_ce && (state_q == StActive)) begin
      if (vd_fall) begin
        sum_d = acc_q;
        acc_d = '0;
      end
      if (den) acc_d = acc_d + {r, g, b};
    end
  end

  // Checksum registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end

  assign frame_sum = sum_q;
`else
  assign frame_sum = 24'h0;
`endif

endmodule

// File: tb/tb_lcd_frame_receiver.sv
// Directed bench for lcd_frame_receiver with H_ACTIVE=4, V_ACTIVE=3 and
// pix_ce asserted on every second clock.
module tb_lcd_frame_receiver;

  localparam int unsigned CW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_ce = 1'b0;
  logic          hd = 1'b1;
  logic          vd = 1'b1;
  logic          den = 1'b0;
  logic [7:0]    r = 8'h0;
  logic [7:0]    g = 8'h0;
  logic [7:0]    b = 8'h0;
  logic          pix_valid;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic [23:0]   pix_rgb;
  logic          frame_done;
  logic          frame_ok;
  logic          err_h;
  logic          err_v;
  logic [15:0]   frame_cnt;
  logic [23:0]   frame_sum;

  int checks = 0;
  int errors = 0;

  // Monitor: collected pixels and frame_done high cycles.
  logic [CW-1:0] qx[$];
  logic [CW-1:0] qy[$];
  logic [23:0]   qc[$];
  int            fd_cnt = 0;

  lcd_frame_receiver #(
    .H_ACTIVE(4),
    .V_ACTIVE(3),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_ce    (pix_ce),
    .hd        (hd),
    .vd        (vd),
    .den       (den),
    .r         (r),
    .g         (g),
    .b         (b),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_rgb   (pix_rgb),
    .frame_done(frame_done),
    .frame_ok  (frame_ok),
    .err_h     (err_h),
    .err_v     (err_v),
    .frame_cnt (frame_cnt),
    .frame_sum (frame_sum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pix_valid === 1'b1) begin
      qx.push_back(pix_x);
      qy.push_back(pix_y);
      qc.push_back(pix_rgb);
    end
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic qclear();
    qx.delete();
    qy.delete();
    qc.delete();
  endtask

  // One accepted sample: pix_ce high for one clock, then low for one clock.
  task automatic sample(input logic v, input logic d, input logic [23:0] c);
    @(negedge clk);
    vd = v;
    hd = v;
    den = d;
    {r, g, b} = c;
    pix_ce = 1'b1;
    @(negedge clk);
    pix_ce = 1'b0;
  endtask

  task automatic line(input int n, input logic [23:0] base, input logic [23:0] step);
    for (int i = 0; i < n; i++) sample(1'b1, 1'b1, base + step * 24'(i));
    sample(1'b1, 1'b0, 24'h0);
  endtask

  task automatic vsync();
    sample(1'b0, 1'b0, 24'h0);
    sample(1'b1, 1'b0, 24'h0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string name, input logic [2:0] exp_st, input logic [15:0] exp_cnt);
    checks++;
    if ({frame_ok, err_h, err_v} !== exp_st) begin
      errors++;
      $display("FAIL %s status {ok,eh,ev}: got %b expected %b", name, {frame_ok, err_h, err_v}, exp_st);
    end
    checks++;
    if (frame_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL %s frame_cnt: got %0d expected %0d", name, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    int fd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pix_ce = ~pix_ce;
      vd = i[0];
      den = i[1];
      r = 8'(i + 1);
    end
    settle();
    checks++;
    if ({pix_valid, pix_x, pix_y, pix_rgb} !== '0) begin
      errors++;
      $display("FAIL reset_pix: got %h expected 0", {pix_valid, pix_x, pix_y, pix_rgb});
    end
    checks++;
    if ({frame_done, frame_ok, err_h, err_v, frame_cnt, frame_sum} !== '0) begin
      errors++;
      $display("FAIL reset_frame: got %h expected 0",
               {frame_done, frame_ok, err_h, err_v, frame_cnt, frame_sum});
    end
    @(negedge clk);
    pix_ce = 1'b0;
    vd = 1'b1;
    den = 1'b0;
    rst = 1'b0;
    qclear();
    fd0 = fd_cnt;
    sample(1'b1, 1'b0, 24'h0);
    line(4, 24'h112233, 24'h0);
    vsync();
    settle();
    checks++;
    if (fd_cnt != fd0) begin
      errors++;
      $display("FAIL first_vd_no_done: got %0d pulses expected 0", fd_cnt - fd0);
    end
    checks++;
    if (qx.size() != 0) begin
      errors++;
      $display("FAIL sync_ignores_den: got %0d pixels expected 0", qx.size());
    end
  endtask

  task automatic test_nominal();
    int fd0;
    qclear();
    fd0 = fd_cnt;
    for (int l = 0; l < 3; l++) line(4, {8'(l), 8'h00, 8'h5A}, 24'h000100);
    vsync();
    settle();
    checks++;
    if (qx.size() != 12) begin
      errors++;
      $display("FAIL nominal_count: got %0d pixels expected 12", qx.size());
    end
    for (int i = 0; i < qx.size() && i < 12; i++) begin
      checks++;
      if (qx[i] !== CW'(i % 4) || qy[i] !== CW'(i / 4) ||
          qc[i] !== {8'(i / 4), 8'(i % 4), 8'h5A}) begin
        errors++;
        $display("FAIL nominal_pix%0d: got x=%0d y=%0d rgb=%h expected x=%0d y=%0d rgb=%h", i,
                 qx[i], qy[i], qc[i], i % 4, i / 4, {8'(i / 4), 8'(i % 4), 8'h5A});
      end
    end
    checks++;
    if (fd_cnt - fd0 != 1) begin
      errors++;
      $display("FAIL nominal_done_width: got %0d cycles expected 1", fd_cnt - fd0);
    end
    checks++;
    if (pix_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL nominal_idle_pulses: got valid=%b done=%b expected 0 0", pix_valid, frame_done);
    end
    check_status("nominal", 3'b100, 16'd1);
  endtask

  task automatic test_short_line();
    line(4, 24'h0, 24'h1);
    line(3, 24'h0, 24'h1);
    line(4, 24'h0, 24'h1);
    vsync();
    settle();
    check_status("short_line", 3'b010, 16'd2);
    for (int l = 0; l < 3; l++) line(4, 24'h0, 24'h1);
    vsync();
    settle();
    check_status("after_short", 3'b100, 16'd3);
  endtask

  task automatic test_missing_line();
    line(4, 24'h0, 24'h1);
    line(4, 24'h0, 24'h1);
    vsync();
    settle();
    check_status("missing_line", 3'b001, 16'd4);
  endtask

  task automatic test_boundary();
    // Frame A: last line ends in the same sample as VD fall.
    line(4, 24'h0, 24'h1);
    line(4, 24'h0, 24'h1);
    for (int i = 0; i < 4; i++) sample(1'b1, 1'b1, 24'h10);
    sample(1'b0, 1'b0, 24'h0);
    sample(1'b1, 1'b0, 24'h0);
    settle();
    check_status("den_vd_same", 3'b100, 16'd5);
    // Frame B ends with a new-frame pixel in the VD-fall sample.
    for (int l = 0; l < 3; l++) line(4, 24'h0, 24'h1);
    qclear();
    sample(1'b0, 1'b1, 24'hC0FFEE);
    settle();
    check_status("vd_with_pixel", 3'b100, 16'd6);
    checks++;
    if (qx.size() != 1 || qx[0] !== 0 || qy[0] !== 0 || qc[0] !== 24'hC0FFEE) begin
      errors++;
      $display("FAIL vd_pixel_coord: got n=%0d x=%0d y=%0d rgb=%h expected n=1 x=0 y=0 rgb=c0ffee",
               qx.size(), qx[0], qy[0], qc[0]);
    end
    for (int i = 1; i < 4; i++) sample(1'b1, 1'b1, 24'h20);
    sample(1'b1, 1'b0, 24'h0);
    line(4, 24'h0, 24'h1);
    line(4, 24'h0, 24'h1);
    vsync();
    settle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (qx[i] !== CW'(i) || qy[i] !== 0) begin
        errors++;
        $display("FAIL new_frame_line0_%0d: got x=%0d y=%0d expected x=%0d y=0", i, qx[i], qy[i], i);
      end
    end
    check_status("frame_c", 3'b100, 16'd7);
  endtask

  task automatic test_stall_reset();
    int fd0;
    logic [23:0] exp_sum;
    qclear();
    sample(1'b1, 1'b1, 24'hAAAAAA);
    sample(1'b1, 1'b1, 24'hBBBBBB);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pix_ce = 1'b0;
      den = ~den;
      r = r + 8'd1;
    end
    settle();
    checks++;
    if (qx.size() != 2) begin
      errors++;
      $display("FAIL stall_no_valid: got %0d pixels expected 2", qx.size());
    end
    sample(1'b1, 1'b1, 24'hCCCCCC);
    settle();
    checks++;
    if (qx.size() != 3 || qx[2] !== 2 || qy[2] !== 0) begin
      errors++;
      $display("FAIL stall_hold_x: got n=%0d x=%0d y=%0d expected n=3 x=2 y=0",
               qx.size(), qx[2], qy[2]);
    end
    check_status("status_hold", 3'b100, 16'd7);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({pix_valid, pix_x, pix_y, pix_rgb, frame_ok, err_h, err_v, frame_cnt, frame_sum} !== '0) begin
      errors++;
      $display("FAIL midframe_reset: got %h expected 0",
               {pix_valid, pix_x, pix_y, pix_rgb, frame_ok, err_h, err_v, frame_cnt, frame_sum});
    end
    @(negedge clk);
    rst = 1'b0;
    den = 1'b0;
    qclear();
    fd0 = fd_cnt;
    sample(1'b1, 1'b0, 24'h0);
    line(4, 24'h0, 24'h1);
    vsync();
    settle();
    checks++;
    if (fd_cnt != fd0 || qx.size() != 0) begin
      errors++;
      $display("FAIL resync_not_reported: got done=%0d pixels=%0d expected 0 0",
               fd_cnt - fd0, qx.size());
    end
    // Checksum frame: 12 pixels of 0x010203.
    for (int l = 0; l < 3; l++) line(4, 24'h010203, 24'h0);
    vsync();
    settle();
    check_status("checksum_frame", 3'b100, 16'd1);
`ifdef LCD_RX_CHECKSUM_EN
    exp_sum = 24'h0C1824;
`else
    exp_sum = 24'h0;
`endif
    checks++;
    if (frame_sum !== exp_sum) begin
      errors++;
      $display("FAIL checksum: got %h expected %h", frame_sum, exp_sum);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_line();
    test_missing_line();
    test_boundary();
    test_stall_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
